// File: rtl/final_addition_sched_pkg.sv
// final_addition_sched_pkg: shared state enum, depth limit and settling-latency helpers.
package final_addition_sched_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RECONF} state_t;
  localparam int MAX_PIPES = 4;
  // Depth p registers the carry out of stage s every (5-p) stages, counted from the top.
  function automatic logic stage_reg(input int pipes, input int s, input int nst);
    return pipes >= 1 && pipes <= MAX_PIPES && ((nst - 1 - s) % (MAX_PIPES + 1 - pipes)) == 0;
  endfunction
  function automatic int lat_of(input int pipes, input int width, input int pstage);
    int n;
    n = 0;
    for (int s = 0; s < width / pstage - 1; s++) n += int'(stage_reg(pipes, s, width / pstage));
    return n;
  endfunction
endpackage

// File: rtl/final_addition.sv
// final_addition: carry-propagate adder whose inter-stage carries are optionally registered.
// Ports: clk, rst_n (async active-low), pipes (depth 0..4), in1/in2 (operands), out ((in1+in2) mod 2^WIDTH).
// Operands must be held for lat_of(pipes)+1 cycles; this is a settling chain, not a streaming pipeline.
module final_addition
  import final_addition_sched_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int PIPE_STAGE_WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       pipes,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out
);
  localparam int P = PIPE_STAGE_WIDTH;
  localparam int S = WIDTH / P;
  logic [S-2:0] co, c_q;
  logic cy;
  always_comb begin
    out = '0;
    co = '0;
    cy = 1'b0;
    for (int s = 0; s < S - 1; s++) begin
      {cy, out[s*P +: P]} = {1'b0, in1[s*P +: P]} + {1'b0, in2[s*P +: P]} + (P+1)'(cy);
      co[s] = cy;
      if (stage_reg(int'(pipes), s, S)) cy = c_q[s];
    end
    out[WIDTH-1 -: P] = in1[WIDTH-1 -: P] + in2[WIDTH-1 -: P] + P'(cy);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) c_q <= '0;
    else c_q <= co;
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin picker starting its search at ptr.
// Ports: req (requests), ptr (search start), en (allow a grant), gnt (one-hot), gnt_idx (granted index).
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);
  always_comb begin
    gnt_idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) gnt_idx = IW'((int'(ptr) + k) % N);
    gnt = (en && |req) ? N'(1) << gnt_idx : '0;
  end
endmodule

// File: rtl/final_addition_sched.sv
// final_addition_sched: shares one final_addition among N_REQ requesters and owns its depth setting.
// Ports: clk, rst_n (async active-low); req_valid/req_ready/req_a/req_b (requester side, packed per index);
// cfg_valid/cfg_pipes/cfg_err (depth change, >4 rejected); active_pipes (depth at the adder);
// rsp_valid/rsp_id/rsp_sum (tagged result pulse); busy (not IDLE).
module final_addition_sched
  import final_addition_sched_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int PIPE_STAGE_WIDTH = 2,
  parameter int N_REQ = 4,
  parameter int ID_W = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic                   cfg_valid,
  input  logic [2:0]             cfg_pipes,
  output logic                   cfg_err,
  output logic [2:0]             active_pipes,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_sum,
  output logic                   busy
);
  localparam int S = WIDTH / PIPE_STAGE_WIDTH;
  localparam int CNT_W = $clog2(S) + 1;
  state_t state, state_n;
  logic [ID_W-1:0] rr_ptr, gnt_idx, cur_id;
  logic [N_REQ-1:0] gnt;
  logic [WIDTH-1:0] op_a, op_b, adder_out;
  logic [CNT_W-1:0] cnt;
  logic [2:0] cfg_pend;
  logic cfg_pend_v, cfg_ok, cfg_req, done, can_grant, accept;
  assign cfg_ok = cfg_valid && cfg_pipes <= 3'(MAX_PIPES);
  assign cfg_req = cfg_pend_v || cfg_ok;
  assign done = state == BUSY && cnt == CNT_W'(lat_of(int'(active_pipes), WIDTH, PIPE_STAGE_WIDTH));
  assign can_grant = !cfg_req && (state == IDLE || done);
  assign accept = |gnt;
  assign req_ready = gnt;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = cfg_req ? RECONF : |req_valid ? BUSY : IDLE;
      BUSY:    state_n = !done ? BUSY : cfg_req ? RECONF : |req_valid ? BUSY : IDLE;
      default: state_n = IDLE;
    endcase
  end
  rr_arbiter #(.N(N_REQ)) u_arb (
    .req(req_valid),
    .ptr(rr_ptr),
    .en(can_grant),
    .gnt(gnt),
    .gnt_idx(gnt_idx)
  );
  final_addition #(.WIDTH(WIDTH), .PIPE_STAGE_WIDTH(PIPE_STAGE_WIDTH)) u_add (
    .clk(clk),
    .rst_n(rst_n),
    .pipes(active_pipes),
    .in1(op_a),
    .in2(op_b),
    .out(adder_out)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      cur_id <= '0;
      op_a <= '0;
      op_b <= '0;
      cnt <= '0;
      cfg_pend <= '0;
      cfg_pend_v <= 1'b0;
      active_pipes <= '0;
      cfg_err <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_sum <= '0;
    end else begin
      state <= state_n;
      rsp_valid <= done;
      cfg_err <= cfg_valid && !cfg_ok;
      if (state == BUSY) cnt <= cnt + 1'b1;
      if (done) begin
        rsp_sum <= adder_out;
        rsp_id <= cur_id;
      end
      if (accept) begin
        op_a <= req_a[gnt_idx*WIDTH +: WIDTH];
        op_b <= req_b[gnt_idx*WIDTH +: WIDTH];
        cur_id <= gnt_idx;
        cnt <= '0;
        rr_ptr <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
      if (state == RECONF) active_pipes <= cfg_pend;
      // A config arriving during RECONF stays pending for another pass.
      if (cfg_ok) begin
        cfg_pend <= cfg_pipes;
        cfg_pend_v <= 1'b1;
      end else if (state == RECONF) cfg_pend_v <= 1'b0;
    end
  end
endmodule

// File: tb/tb_final_addition_sched.sv
// tb_final_addition_sched: scoreboard bench for final_addition_sched.
module tb_final_addition_sched;
  localparam int W = 16;
  localparam int N = 4;
  localparam int IDW = 2;
  localparam int LATT [5] = '{0, 1, 2, 3, 7};
  typedef struct {
    int id;
    logic [W-1:0] sum;
    int due;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic cfg_valid = 1'b0;
  logic [2:0] cfg_pipes = '0;
  logic cfg_err, rsp_valid, busy;
  logic [2:0] active_pipes;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0] rsp_sum;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int exp_pipes = 0, gap_exp = 0, last_acc = -1, mptr = 0, ei = 0;
  int head [N] = '{0, 0, 0, 0};
  int tail [N] = '{0, 0, 0, 0};
  logic [W-1:0] ja [N][64];
  logic [W-1:0] jb [N][64];
  logic [W-1:0] sm;
  exp_t sb [$];
  exp_t e;
  final_addition_sched #(.WIDTH(W), .PIPE_STAGE_WIDTH(2), .N_REQ(N), .ID_W(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .cfg_valid(cfg_valid), .cfg_pipes(cfg_pipes),
    .cfg_err(cfg_err), .active_pipes(active_pipes), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic enqueue(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    ja[i][tail[i] % 64] = a;
    jb[i][tail[i] % 64] = b;
    tail[i]++;
  endtask
  function automatic bit all_done();
    for (int i = 0; i < N; i++) if (head[i] != tail[i]) return 1'b0;
    return sb.size() == 0 && !busy && !rsp_valid;
  endfunction
  task automatic drain(input int budget);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!all_done() && k < budget);
    if (!all_done()) check("drain_timeout", 0, 1);
  endtask
  task automatic wait_accept();
    int k;
    k = 0;
    while (sb.size() == 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() == 0) check("accept_timeout", 0, 1);
  endtask
  task automatic set_cfg(input int p);
    @(posedge clk);
    #1 cfg_valid = 1'b1;
    cfg_pipes = 3'(p);
    @(posedge clk);
    #1 cfg_valid = 1'b0;
    @(negedge clk);
    if (p > 4) begin
      check("cfg_err_pulse", cfg_err, 1);
      check("cfg_err_keeps_pipes", active_pipes, exp_pipes);
      @(negedge clk);
      check("cfg_err_clear", cfg_err, 0);
    end else begin
      check("reconf_busy", busy, 1);
      check("reconf_no_ready", req_ready, 0);
      exp_pipes = p;
      @(negedge clk);
      check("active_pipes", active_pipes, p);
    end
  endtask
  task automatic check_reset_outputs();
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_sum", rsp_sum, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_active_pipes", active_pipes, 0);
    check("rst_busy", busy, 0);
  endtask
  // Drives each requester's head job; a job leaves the queue once accepted.
  initial forever begin
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = head[i] < tail[i];
      req_a[i*W +: W] = ja[i][head[i] % 64];
      req_b[i*W +: W] = jb[i][head[i] % 64];
    end
  end
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      mptr = 0;
    end else begin
      if (rsp_valid) begin
        if (sb.size() == 0) check("unexpected_rsp", 1, 0);
        else begin
          e = sb.pop_front();
          check("rsp_id", rsp_id, e.id);
          check("rsp_sum", rsp_sum, e.sum);
          check("rsp_cycle", cyc, e.due);
        end
      end
      if (gap_exp == 0) last_acc = -1;
      if (req_ready != '0) begin
        check("ready_onehot", $countones(req_ready), 1);
        check("ready_without_valid", req_ready & ~req_valid, 0);
        ei = -1;
        for (int k = N - 1; k >= 0; k--) if (req_valid[(mptr + k) % N]) ei = (mptr + k) % N;
        for (int i = 0; i < N; i++) if (req_ready[i] && req_valid[i]) begin
          check("rr_grant", i, ei);
          mptr = (i + 1) % N;
          sm = ja[i][head[i] % 64] + jb[i][head[i] % 64];
          sb.push_back('{id: i, sum: sm, due: cyc + LATT[exp_pipes] + 2});
          head[i]++;
          if (gap_exp != 0 && last_acc >= 0) check("grant_gap", cyc - last_acc, gap_exp);
          last_acc = cyc;
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1 rst_n = 1'b1;
    enqueue(0, 16'd1, 16'd2);
    drain(50);
    set_cfg(4);
    enqueue(1, 16'd4562, 16'd4544);
    drain(50);
    set_cfg(2);
    gap_exp = 3;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) enqueue(i, 16'(1000 * i + 77 * r + 5), 16'(65000 - 333 * i + r));
    drain(200);
    gap_exp = 0;
    set_cfg(1);
    enqueue(0, 16'hFFFF, 16'h0001);
    wait_accept();
    @(posedge clk);
    #1 cfg_valid = 1'b1;
    cfg_pipes = 3'd3;
    exp_pipes = 3;
    enqueue(1, 16'h8000, 16'h8000);
    @(posedge clk);
    #1 cfg_valid = 1'b0;
    drain(100);
    check("mid_busy_cfg_applied", active_pipes, 3);
    set_cfg(6);
    enqueue(3, 16'h1234, 16'hEDCC);
    set_cfg(2);
    drain(100);
    set_cfg(4);
    enqueue(2, 16'hAAAA, 16'h5555);
    wait_accept();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    exp_pipes = 0;
    @(negedge clk);
    check_reset_outputs();
    repeat (2) @(negedge clk);
    check("rst_hold_rsp_valid", rsp_valid, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = N - 1; i >= 0; i--) enqueue(i, 16'(i + 10), 16'(i * 3));
    drain(100);
    set_cfg(4);
    for (int v = 0; v < 50; v++) enqueue(int'($urandom_range(0, N - 1)), 16'($urandom), 16'($urandom));
    drain(2000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
